// File: rtl/tt_um_serial_sub_example.sv
// rtl/tt_um_serial_sub_example.sv - bit-serial 8-bit subtractor recovering an addend from a sum
//
// Computes (A - B) mod 256 LSB first over 8 clocks after an accepted START.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   ena          enable; when low every register holds
//   ui_in[7:0]   operand data, captured by LOAD_A / LOAD_B
//   uio_in[1:0]  command: 00 idle, 01 LOAD_A, 10 LOAD_B, 11 START (edge-accepted)
//   uo_out[7:0]  result register, valid while done=1
//   uio_out[7:5] busy, done, borrow; [4:0] tied low
//   uio_oe[7:0]  constant 8'hE0
module tt_um_serial_sub_example (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [1:0] cmd;
    logic [1:0] cmd_prev;
    logic       accept;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] sa;
    logic [7:0] sb;
    logic [7:0] res_q;
    logic [2:0] cnt;
    logic       br;
    logic       br_next;
    logic       d;
    logic       borrow;
    logic       done;
    logic       busy;
    logic       unused_ok;

    assign cmd       = uio_in[1:0];
    assign unused_ok = &{1'b0, uio_in[7:2]};
    assign busy      = (state == S_RUN);

    // A command acts once, on the first cycle it leaves 00; level changes
    // between two non-idle codes are not new commands.
    assign accept = (cmd != 2'b00) && (cmd_prev == 2'b00);

    // One full-subtractor bit per clock.
    assign d       = sa[0] ^ sb[0] ^ br;
    assign br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (ena && accept && (cmd == 2'b11)) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (ena && (cnt == 3'd7)) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_prev <= 2'b00;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            sa       <= 8'h00;
            sb       <= 8'h00;
            res_q    <= 8'h00;
            cnt      <= 3'd0;
            br       <= 1'b0;
            borrow   <= 1'b0;
            done     <= 1'b0;
        end else if (ena) begin
            cmd_prev <= cmd;
            if (busy) begin
                // Commands arriving mid-operation are dropped, not queued.
                res_q <= {d, res_q[7:1]};
                sa    <= {1'b0, sa[7:1]};
                sb    <= {1'b0, sb[7:1]};
                br    <= br_next;
                cnt   <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    done   <= 1'b1;
                    borrow <= br_next;
                end
            end else if (accept) begin
                case (cmd)
                    2'b01: begin
                        a_q  <= ui_in;
                        done <= 1'b0;
                    end
                    2'b10: begin
                        b_q  <= ui_in;
                        done <= 1'b0;
                    end
                    2'b11: begin
                        done   <= 1'b0;
                        cnt    <= 3'd0;
                        br     <= 1'b0;
                        borrow <= 1'b0;
                        sa     <= a_q;
                        sb     <= b_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign uo_out  = res_q;
    assign uio_out = {busy, done, borrow, 5'b00000};
    assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_tt_um_serial_sub_example.sv
// tb/tb_tt_um_serial_sub_example.sv - self-checking bench for the serial subtractor
module tb_tt_um_serial_sub_example;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad   = 0;

    tt_um_serial_sub_example dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle command pulse followed by a return to idle.
    task automatic pulse(input logic [1:0] c, input logic [7:0] data);
        @(negedge clk);
        uio_in = {6'b000000, c};
        ui_in  = data;
        @(negedge clk);
        uio_in = 8'h00;
    endtask

    // Count cycles busy stays high, starting at the negedge after the START edge.
    task automatic count_busy(output int n);
        n = 0;
        while (uio_out[7] === 1'b1 && n < 30) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input logic [7:0] exp_res, input logic exp_br, input string tag);
        total++;
        if (uio_out[6] !== 1'b1) begin
            bad++;
            $display("FAIL %s done: got %b want 1", tag, uio_out[6]);
        end
        total++;
        if (uo_out !== exp_res) begin
            bad++;
            $display("FAIL %s result: got %02h want %02h", tag, uo_out, exp_res);
        end
        total++;
        if (uio_out[5] !== exp_br) begin
            bad++;
            $display("FAIL %s borrow: got %b want %b", tag, uio_out[5], exp_br);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag);
        int n;
        int diff;
        logic [7:0] exp_res;
        diff    = (int'(a) - int'(b) + 256) % 256;
        exp_res = diff[7:0];
        pulse(2'b01, a);
        pulse(2'b10, b);
        pulse(2'b11, $urandom);
        count_busy(n);
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL %s busy_len: got %0d want 8", tag, n);
        end
        check_result(exp_res, (a < b), tag);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = $urandom;
        uio_in = $urandom;
        #3;
        total++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hE0) begin
            bad++;
            $display("FAIL reset_outputs: got uo=%02h uio=%02h oe=%02h want 00 00 E0",
                     uo_out, uio_out, uio_oe);
        end
        @(negedge clk);
        uio_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hE0) begin
                bad++;
                $display("FAIL idle_after_reset: cycle %0d got uo=%02h uio=%02h oe=%02h",
                         i, uo_out, uio_out, uio_oe);
            end
        end
    endtask

    task automatic test_basic();
        run_op(8'd200, 8'd55, "basic_200_55");
    endtask

    task automatic test_boundaries();
        run_op(8'd5, 8'd10, "underflow_5_10");
        run_op(8'h80, 8'h80, "equal_80");
        run_op(8'h00, 8'hFF, "zero_minus_ff");
        run_op(8'hFF, 8'h00, "ff_minus_zero");
    endtask

    task automatic test_hold_start();
        int busy_cycles;
        int rises;
        logic prev_busy;
        pulse(2'b01, 8'd200);
        pulse(2'b10, 8'd55);
        busy_cycles = 0;
        rises       = 0;
        prev_busy   = 1'b0;
        @(negedge clk);
        uio_in = 8'h03;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uio_out[7] === 1'b1) busy_cycles++;
            if (uio_out[7] === 1'b1 && !prev_busy) rises++;
            prev_busy = uio_out[7];
        end
        uio_in = 8'h00;
        @(negedge clk);
        total++;
        if (busy_cycles != 8 || rises != 1) begin
            bad++;
            $display("FAIL hold_start: got busy_cycles=%0d rises=%0d want 8 and 1", busy_cycles, rises);
        end
        check_result(8'd145, 1'b0, "hold_start");
    endtask

    task automatic test_busy_ignore();
        int n;
        pulse(2'b11, 8'h00);
        @(negedge clk);
        uio_in = 8'h02;
        ui_in  = 8'hFF;
        @(negedge clk);
        uio_in = 8'h00;
        @(negedge clk);
        uio_in = 8'h03;
        @(negedge clk);
        uio_in = 8'h00;
        count_busy(n);
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL busy_ignore_len: got %0d remaining busy cycles want 4", n);
        end
        check_result(8'd145, 1'b0, "busy_ignore");
        // A restart without reloading must see the original B.
        pulse(2'b11, 8'h00);
        count_busy(n);
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL rerun_len: got %0d want 8", n);
        end
        check_result(8'd145, 1'b0, "rerun_no_reload");
        // No busy pulse from the queued START.
        repeat (3) @(negedge clk);
        total++;
        if (uio_out[7] !== 1'b0) begin
            bad++;
            $display("FAIL start_not_queued: got busy %b want 0", uio_out[7]);
        end
    endtask

    task automatic test_cmd_edges();
        int seen;
        pulse(2'b01, 8'd7);
        pulse(2'b10, 8'd3);
        @(negedge clk);
        uio_in = 8'h01;
        ui_in  = 8'd9;
        @(negedge clk);
        uio_in = 8'h03;
        @(negedge clk);
        uio_in = 8'h00;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (uio_out[7] === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL direct_01_to_11: got %0d busy cycles want 0", seen);
        end
        // The LOAD_A part of that sequence was accepted, so A=9.
        run_op(8'd9, 8'd3, "after_01_11");
        // A command pulse made entirely while ena=0 is lost.
        @(negedge clk);
        ena = 1'b0;
        pulse(2'b11, 8'h00);
        @(negedge clk);
        ena  = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (uio_out[7] === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL ena_low_cmd_lost: got %0d busy cycles want 0", seen);
        end
    endtask

    task automatic test_midop_reset();
        pulse(2'b01, 8'd200);
        pulse(2'b10, 8'd55);
        pulse(2'b11, 8'h00);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hE0) begin
            bad++;
            $display("FAIL midop_reset: got uo=%02h uio=%02h oe=%02h want 00 00 E0",
                     uo_out, uio_out, uio_oe);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'd200, 8'd55, "after_reset");
    endtask

    task automatic test_round_trip();
        int x;
        int y;
        int n;
        int sum;
        logic [7:0] a;
        logic [7:0] yb;
        logic [7:0] xb;
        for (int i = 0; i < 200; i++) begin
            x   = $urandom_range(0, 255);
            y   = $urandom_range(0, 255);
            sum = x + y;
            a   = sum[7:0];
            yb  = y[7:0];
            xb  = x[7:0];
            pulse(2'b01, a);
            pulse(2'b10, yb);
            pulse(2'b11, $urandom);
            count_busy(n);
            total++;
            if (n != 8) begin
                bad++;
                $display("FAIL round_trip_len %0d: got %0d want 8", i, n);
            end
            total++;
            if (uo_out !== xb || uio_out[5] !== (sum >= 256)) begin
                bad++;
                $display("FAIL round_trip %0d: x=%0d y=%0d got res=%0d br=%b want res=%0d br=%b",
                         i, x, y, uo_out, uio_out[5], x, (sum >= 256));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_hold_start();
        test_busy_ignore();
        test_cmd_edges();
        test_midop_reset();
        test_round_trip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
